// File: rtl/aes_pkg.sv
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES key-schedule types, mode constants, S-box and helpers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  typedef enum logic [1:0] {
    AES128 = 2'd0,
    AES192 = 2'd1,
    AES256 = 2'd2
  } key_len_t;

  localparam int NB = 4;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sub_word.sv
// ============================================================================
// Module   : aes_sub_word
// Brief    : Combinational AES SubWord, four parallel S-box lookups.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign o_word[8*b +: 8] = SBOX[i_word[8*b +: 8]];
  end

endmodule

`default_nettype wire

// File: rtl/aes_key_schedule_seq.sv
// ============================================================================
// Module   : aes_key_schedule_seq
// Brief    : Sequential 128/192/256-bit AES key expander, one word per clock,
//            with an indexed round-key read port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int MAX_NR = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  key_ready,
  output logic                  err,
  output logic [3:0]            num_rounds,
  input  logic [3:0]            rk_addr,
  output logic [127:0]          rk_data
);

  localparam int BUF_WORDS = NB * (MAX_NR + 1);
  localparam int AW        = $clog2(BUF_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_nk, r_nr, w_nk, w_nr;
  logic [AW-1:0]         r_idx, r_last, w_last;
  logic [2:0]            r_mod;
  logic [7:0]            r_rcon;
  logic [32*MAX_NK-1:0]  r_key;
  logic                  r_key_ready, r_err;
  logic [31:0]           r_buf [BUF_WORDS];

  logic                  w_accept, w_reject;
  logic                  w_rot_slot, w_sub_slot, w_mod_wrap;
  logic [31:0]           w_prev, w_back, w_sub_in, w_sub_out, w_temp, w_new;
  logic [AW-1:0]         w_base;

  always_comb begin
    w_nk = NK_128;
    w_nr = NR_128;
    case (key_len_t'(key_len))
      AES192: begin
        w_nk = NK_192;
        w_nr = NR_192;
      end
      AES256: begin
        w_nk = NK_256;
        w_nr = NR_256;
      end
      default: ;
    endcase
    w_last = AW'(NB * (int'(w_nr) + 1) - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (key_len == 2'd3) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        busy        = 1'b1;
        w_state_nxt = S_EXPAND;
      end
      S_EXPAND: begin
        busy = 1'b1;
        if (r_idx == r_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_mod mirrors i mod Nk so the rotate/rcon and 256-bit SubWord slots need no divider.
  always_comb begin
    w_prev     = r_buf[r_idx - AW'(1)];
    w_back     = r_buf[r_idx - AW'(r_nk)];
    w_rot_slot = (r_mod == 3'd0);
    w_sub_slot = (r_nk == NK_256) && (r_mod == 3'd4);
    w_mod_wrap = ({1'b0, r_mod} == (r_nk - 4'd1));
    w_sub_in   = w_rot_slot ? rot_word(w_prev) : w_prev;
    if (w_rot_slot)      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    else if (w_sub_slot) w_temp = w_sub_out;
    else                 w_temp = w_prev;
    w_new = w_back ^ w_temp;
  end

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nk        <= NK_128;
      r_nr        <= 4'd0;
      r_last      <= '0;
      r_key       <= '0;
      r_idx       <= '0;
      r_mod       <= 3'd0;
      r_rcon      <= 8'h01;
      r_key_ready <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_nk        <= w_nk;
        r_nr        <= w_nr;
        r_last      <= w_last;
        r_key       <= key_in;
        r_key_ready <= 1'b0;
      end
      case (r_state)
        S_LOAD: begin
          r_idx  <= AW'(r_nk);
          r_mod  <= 3'd0;
          r_rcon <= 8'h01;
        end
        S_EXPAND: begin
          r_idx <= r_idx + AW'(1);
          r_mod <= w_mod_wrap ? 3'd0 : r_mod + 3'd1;
          if (w_rot_slot) r_rcon <= xtime(r_rcon);
          if (r_idx == r_last) r_key_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Schedule storage carries no reset; reads are masked by key_ready.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (j < int'(r_nk)) r_buf[j] <= r_key[32*(MAX_NK-j)-1 -: 32];
      end
    end else if (r_state == S_EXPAND) begin
      r_buf[r_idx] <= w_new;
    end
  end

  always_comb begin
    w_base  = AW'({rk_addr, 2'b00});
    rk_data = '0;
    if (r_key_ready && (rk_addr <= r_nr)) begin
      rk_data = {r_buf[w_base], r_buf[w_base + AW'(1)],
                 r_buf[w_base + AW'(2)], r_buf[w_base + AW'(3)]};
    end
  end

  assign key_ready  = r_key_ready;
  assign err        = r_err;
  assign num_rounds = r_nr;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule_seq.sv
// ============================================================================
// Module   : tb_aes_key_schedule_seq
// Brief    : Directed self-checking bench for aes_key_schedule_seq (FIPS-197 vectors).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_key_schedule_seq;

  localparam logic [255:0] C_KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                       128'h0123456789abcdef0011223344556677};
  localparam logic [255:0] C_KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                       64'hfedcba9876543210};
  localparam logic [255:0] C_KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, done, key_ready, err;
  logic [3:0]   num_rounds, rk_addr;
  logic [127:0] rk_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int edges;
  int n_done;

  aes_key_schedule_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_len    (key_len),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .key_ready  (key_ready),
    .err        (err),
    .num_rounds (num_rounds),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge (edge 0), then scramble key_in to prove it is not resampled.
  task automatic start_run(input logic [1:0] len, input logic [255:0] key);
    key_len = len;
    key_in  = key;
    start   = 1'b1;
    tick();
    start  = 1'b0;
    key_in = ~key;
  endtask

  // Counts edges after edge 0 until done; optionally re-pulses start at edge pulse_edge.
  task automatic wait_done(input int pulse_edge, output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (pulse_edge > 0 && n == pulse_edge - 1) start = 1'b1;
      tick();
      n++;
      if (start) begin
        start = 1'b0;
        check("restart_err", {127'd0, err}, 128'd0);
      end
    end
  endtask

  task automatic read_rk(input string tag, input logic [3:0] a, input logic [127:0] exp);
    rk_addr = a;
    #1;
    check(tag, rk_data, exp);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    key_len = 2'd0;
    key_in  = '0;
    rk_addr = 4'd0;
    repeat (3) tick();
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_key_ready", {127'd0, key_ready}, 128'd0);
    check("rst_err", {127'd0, err}, 128'd0);
    check("rst_num_rounds", {124'd0, num_rounds}, 128'd0);
    check("rst_rk_data", rk_data, 128'd0);
    rst = 1'b0;
    tick();

    // AES-128
    start_run(2'd0, C_KEY128);
    check("a128_busy", {127'd0, busy}, 128'd1);
    wait_done(0, edges);
    check("a128_latency", 128'(edges), 128'd41);
    check("a128_key_ready", {127'd0, key_ready}, 128'd1);
    check("a128_nr", {124'd0, num_rounds}, 128'd10);
    read_rk("a128_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk("a128_rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk("a128_rk0", 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_rk("a128_rk11", 4'd11, 128'd0);
    tick();
    check("a128_done_pulse", {127'd0, done}, 128'd0);
    check("a128_idle", {127'd0, busy}, 128'd0);

    // Illegal key length keeps the previous schedule
    key_len = 2'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("ill_err", {127'd0, err}, 128'd1);
    check("ill_busy", {127'd0, busy}, 128'd0);
    check("ill_key_ready", {127'd0, key_ready}, 128'd1);
    read_rk("ill_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    check("ill_err_pulse", {127'd0, err}, 128'd0);

    // AES-192 with a second start at edge 10 that must be ignored
    start_run(2'd1, C_KEY192);
    check("a192_ready_drop", {127'd0, key_ready}, 128'd0);
    key_len = 2'd2;
    wait_done(10, edges);
    check("a192_latency", 128'(edges), 128'd47);
    check("a192_nr", {124'd0, num_rounds}, 128'd12);
    read_rk("a192_rk12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);
    read_rk("a192_rk1", 4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    read_rk("a192_rk0", 4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5);
    read_rk("a192_rk13", 4'd13, 128'd0);
    tick();

    // AES-256
    start_run(2'd2, C_KEY256);
    wait_done(0, edges);
    check("a256_latency", 128'(edges), 128'd53);
    check("a256_nr", {124'd0, num_rounds}, 128'd14);
    read_rk("a256_rk14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
    read_rk("a256_rk3", 4'd3, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    read_rk("a256_rk1", 4'd1, 128'h1f352c073b6108d72d9810a30914dff4);
    read_rk("a256_rk15", 4'd15, 128'd0);
    tick();

    // Reset in the middle of an AES-256 run
    start_run(2'd2, C_KEY256);
    repeat (20) tick();
    rst     = 1'b1;
    rk_addr = 4'd14;
    #1;
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    check("mid_rst_done", {127'd0, done}, 128'd0);
    check("mid_rst_key_ready", {127'd0, key_ready}, 128'd0);
    check("mid_rst_err", {127'd0, err}, 128'd0);
    check("mid_rst_nr", {124'd0, num_rounds}, 128'd0);
    check("mid_rst_rk_data", rk_data, 128'd0);
    tick();
    rst    = 1'b0;
    n_done = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done) n_done++;
    end
    check("mid_rst_no_done", 128'(n_done), 128'd0);
    check("mid_rst_idle", {127'd0, busy}, 128'd0);

    start_run(2'd0, C_KEY128);
    wait_done(0, edges);
    check("rerun_latency", 128'(edges), 128'd41);
    read_rk("rerun_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
